updown_count_monitor: RTL

//  Observes the Count output of an up/down counter (e.g. fourbit_Sync_UpDown) and decodes it.

---
 rtl/updown_count_monitor.sv | 123 ++++++++++++
 1 files changed

// File: rtl/updown_count_monitor.sv
// Decodes an up/down counter's Count bus: direction lock, illegal-jump detection,
// wrap-around pulses and a saturating error tally. All outputs are registered.
module updown_count_monitor #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned LOCK_N = 3
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Count_in,
  input  logic             Valid,
  output logic             Dir_up,
  output logic             Dir_down,
  output logic             Locked,
  output logic             Step_err,
  output logic             Wrap_pulse,
  output logic [7:0]       Err_count
);

  typedef enum logic [1:0] {StInit, StTrack, StUpLock, StDownLock} state_e;

  localparam logic [WIDTH-1:0] MaxVal = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] OneVal = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LockN  = 4'(LOCK_N);

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_prev, w_prev_next, w_delta;
  logic [3:0]       r_run_up, r_run_dn, w_run_up_next, w_run_dn_next;
  logic [3:0]       w_run_up_inc, w_run_dn_inc;
  logic [7:0]       r_err_count, w_err_count_next;
  logic             r_step_err, w_step_err_next;
  logic             r_wrap, w_wrap_next;
  logic             w_up, w_dn, w_hold;

  // Modular difference classifies the step independent of wrap-around.
  assign w_delta = Count_in - r_prev;
  assign w_up    = (w_delta == OneVal);
  assign w_dn    = (w_delta == MaxVal);
  assign w_hold  = (w_delta == '0);

  assign w_run_up_inc = (r_run_up >= LockN) ? LockN : r_run_up + 4'd1;
  assign w_run_dn_inc = (r_run_dn >= LockN) ? LockN : r_run_dn + 4'd1;

  always_comb begin
    w_state_next     = r_state;
    w_prev_next      = r_prev;
    w_run_up_next    = r_run_up;
    w_run_dn_next    = r_run_dn;
    w_err_count_next = r_err_count;
    w_step_err_next  = 1'b0;
    w_wrap_next      = 1'b0;

    if (Valid) begin
      w_prev_next = Count_in;
      if (r_state == StInit) begin
        w_state_next = StTrack;
      end else if (w_up) begin
        w_wrap_next = (r_prev == MaxVal);
        case (r_state)
          StTrack: begin
            w_run_up_next = w_run_up_inc;
            w_run_dn_next = 4'd0;
            if (w_run_up_inc == LockN) w_state_next = StUpLock;
          end
          StDownLock: begin
            w_run_up_next = 4'd1;
            w_run_dn_next = 4'd0;
            w_state_next  = (LockN == 4'd1) ? StUpLock : StTrack;
          end
          default: ;
        endcase
      end else if (w_dn) begin
        w_wrap_next = (r_prev == '0);
        case (r_state)
          StTrack: begin
            w_run_dn_next = w_run_dn_inc;
            w_run_up_next = 4'd0;
            if (w_run_dn_inc == LockN) w_state_next = StDownLock;
          end
          StUpLock: begin
            w_run_dn_next = 4'd1;
            w_run_up_next = 4'd0;
            w_state_next  = (LockN == 4'd1) ? StDownLock : StTrack;
          end
          default: ;
        endcase
      end else if (!w_hold) begin
        w_step_err_next  = 1'b1;
        w_err_count_next = (r_err_count == 8'hFF) ? 8'hFF : r_err_count + 8'd1;
        w_run_up_next    = 4'd0;
        w_run_dn_next    = 4'd0;
        w_state_next     = StTrack;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      r_state     <= StInit;
      r_prev      <= '0;
      r_run_up    <= 4'd0;
      r_run_dn    <= 4'd0;
      r_err_count <= 8'd0;
      r_step_err  <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_prev      <= w_prev_next;
      r_run_up    <= w_run_up_next;
      r_run_dn    <= w_run_dn_next;
      r_err_count <= w_err_count_next;
      r_step_err  <= w_step_err_next;
      r_wrap      <= w_wrap_next;
    end
  end

  assign Dir_up     = (r_state == StUpLock);
  assign Dir_down   = (r_state == StDownLock);
  assign Locked     = Dir_up | Dir_down;
  assign Step_err   = r_step_err;
  assign Wrap_pulse = r_wrap;
  assign Err_count  = r_err_count;

endmodule
